// File: rtl/hazard_ctrl.sv
// Pipeline hazard/flow control: load-use stall, redirect squash, data-memory freeze,
// debug halt/drain/resume sequencing and saturating stall/flush performance counters.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT  = 255,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_MemRead,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             halt_req,
   input  logic             resume_req,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_stall,
   output logic             memwb_bubble,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

   state_t             state;
   state_t             eff_state;
   logic               ret_drain;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [WAIT_W-1:0]  next_wait;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               freeze;
   logic               lu;
   logic               redirect_ok;

   always_comb begin
      freeze       = ~rst & mem_req & ~mem_ready & (state != HALTED);
      lu           = ex_MemRead & (ex_rd != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
      redirect_ok  = ~rst & ~freeze & ex_redirect;
      next_wait    = (state == MEM_WAIT) ? wait_cnt + WAIT_W'(1) : WAIT_W'(1);
      // The non-freeze cycle that ends a memory wait behaves as the state it interrupted,
      // so a freeze inside DRAIN stretches the drain by exactly the freeze length.
      eff_state    = state;
      if (state == MEM_WAIT)
         eff_state = ret_drain ? DRAIN : RUN;

      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      exmem_stall  = 1'b0;
      memwb_bubble = 1'b0;
      if (!rst) begin
         if (freeze) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            exmem_stall  = 1'b1;
            memwb_bubble = 1'b1;
         end else if (ex_redirect) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
         end else if (lu) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_flush   = 1'b1;
         end else if (eff_state == DRAIN) begin
            pc_stall     = 1'b1;
            ifid_flush   = 1'b1;
         end else if (eff_state == HALTED) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_flush   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         ret_drain   <= 1'b0;
         wait_cnt    <= '0;
         drain_cnt   <= '0;
         halted      <= 1'b0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         if (pc_stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (redirect_ok && flush_cnt != '1)
            flush_cnt <= flush_cnt + CNT_W'(1);

         if (freeze) begin
            if (next_wait >= WAIT_W'(MEM_TIMEOUT)) begin
               mem_timeout <= 1'b1;
               halted      <= 1'b1;
               state       <= HALTED;
            end else begin
               state    <= MEM_WAIT;
               wait_cnt <= next_wait;
               if (state != MEM_WAIT)
                  ret_drain <= (state == DRAIN);
            end
         end else begin
            case (eff_state)
               RUN: begin
                  state <= RUN;
                  if (halt_req) begin
                     state     <= DRAIN;
                     drain_cnt <= '0;
                  end
               end
               DRAIN: begin
                  if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end else begin
                     state     <= DRAIN;
                     drain_cnt <= drain_cnt + DRAIN_W'(1);
                  end
               end
               HALTED: begin
                  if (resume_req && !halt_req) begin
                     state  <= RUN;
                     halted <= 1'b0;
                  end
               end
               default: state <= RUN;
            endcase
         end
      end
   end

endmodule
